acc_control_fsm: RTL and testbench

- Multicycle control unit for the accumulator processor.
- Decodes the 4-bit opcode from the instruction register and sequences fetch, decode, execute and writeback.
- Drives every datapath select and write enable.
- Its ALUSrcB output is the 2-bit Op select of the downstream 3-bit, 3-input operand mux; codes 10 and 11 both select input C.

---
 rtl/acc_control_fsm.sv | 174 +++++++++++++++++
 tb/tb_acc_control_fsm.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/acc_control_fsm.sv
// Multicycle control FSM for the accumulator processor.
// The state register holds the instruction phase. Every datapath select and
// write enable is decoded from that phase and from the opcode that the IR holds.
// Handshake: none. The unit free-runs one phase per clock. Reset high masks all
// strobes in the same cycle and returns the machine to FETCH on the next edge.
module acc_control_fsm #(
  parameter int OPW = 4,
  parameter int STW = 4
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic [OPW-1:0] Opcode,
  input  logic           AccZero,
  output logic           PCWrite,
  output logic [1:0]     PCSrc,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [2:0]     ALUOp,
  output logic           MemToAcc,
  output logic           AccWrite,
  output logic           Halted,
  output logic [STW-1:0] State
);

  typedef enum logic [STW-1:0] {
    S_FETCH   = STW'(0),
    S_DECODE  = STW'(1),
    S_MEMREAD = STW'(2),
    S_ALUEXEC = STW'(3),
    S_ACCWB   = STW'(4),
    S_STORE   = STW'(5),
    S_BRANCH  = STW'(6),
    S_JUMP    = STW'(7),
    S_HALT    = STW'(8)
  } state_t;

  localparam logic [OPW-1:0] OP_LOAD  = OPW'(0);
  localparam logic [OPW-1:0] OP_STORE = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(3);
  localparam logic [OPW-1:0] OP_AND   = OPW'(4);
  localparam logic [OPW-1:0] OP_OR    = OPW'(5);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6);
  localparam logic [OPW-1:0] OP_BEQZ  = OPW'(7);
  localparam logic [OPW-1:0] OP_JUMP  = OPW'(8);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(15);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [1:0] SRCB_MDR  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_TWO  = 2'b10;

  state_t state_q;
  state_t state_d;

  // ALU function for the arithmetic and logic opcodes (ADDI uses add).
  function automatic logic [2:0] alu_sel(input logic [OPW-1:0] op);
    case (op)
      OP_SUB:  alu_sel = ALU_SUB;
      OP_AND:  alu_sel = ALU_AND;
      OP_OR:   alu_sel = ALU_OR;
      default: alu_sel = ALU_ADD;
    endcase
  endfunction

  // State register: reset or any undefined encoding lands in FETCH.
  always_ff @(posedge CLK) begin
    if (Reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and output decode. Outputs default to 0 and reset masks all strobes.
  always_comb begin
    state_d  = S_FETCH;
    PCWrite  = 1'b0;
    PCSrc    = 2'b00;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_MDR;
    ALUOp    = ALU_ADD;
    MemToAcc = 1'b0;
    AccWrite = 1'b0;
    Halted   = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = SRCB_TWO;
        PCWrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode is decoded.
        ALUSrcB = SRCB_IMM;
        case (Opcode)
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_MEMREAD;
          OP_ADDI:  state_d = S_ALUEXEC;
          OP_STORE: state_d = S_STORE;
          OP_BEQZ:  state_d = S_BRANCH;
          OP_JUMP:  state_d = S_JUMP;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = (Opcode == OP_LOAD) ? S_ACCWB : S_ALUEXEC;
      end
      S_ALUEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = (Opcode == OP_ADDI) ? SRCB_IMM : SRCB_MDR;
        ALUOp   = alu_sel(Opcode);
        state_d = S_ACCWB;
      end
      S_ACCWB: begin
        AccWrite = 1'b1;
        if (Opcode == OP_LOAD) begin
          MemToAcc = 1'b1;
        end else begin
          // Hold the ALU controls so the result stays valid while ACC loads.
          ALUSrcA = 1'b1;
          ALUSrcB = (Opcode == OP_ADDI) ? SRCB_IMM : SRCB_MDR;
          ALUOp   = alu_sel(Opcode);
        end
        state_d = S_FETCH;
      end
      S_STORE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        PCSrc   = 2'b10;
        PCWrite = AccZero;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b01;
        state_d = S_FETCH;
      end
      S_HALT: begin
        Halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase

    if (Reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      AccWrite = 1'b0;
      Halted   = 1'b0;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_acc_control_fsm.sv
// Bench for acc_control_fsm. Each instruction is expanded into its expected
// list of phases from the instruction timing table. Every cycle the full output
// word is compared against the outputs that the table lists for that phase.
module tb_acc_control_fsm;

  logic       CLK;
  logic       Reset;
  logic [3:0] Opcode;
  logic       AccZero;
  logic       PCWrite;
  logic [1:0] PCSrc;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic       MemToAcc;
  logic       AccWrite;
  logic       Halted;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];

  acc_control_fsm #(.OPW(4), .STW(4)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .AccZero(AccZero),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .MemToAcc(MemToAcc),
    .AccWrite(AccWrite), .Halted(Halted), .State(State)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Observed output word: {State, PCWrite, PCSrc, IorD, MemRead, MemWrite,
  // IRWrite, ALUSrcA, ALUSrcB, ALUOp, MemToAcc, AccWrite, Halted}
  function automatic logic [19:0] obs_word();
    return {State, PCWrite, PCSrc, IorD, MemRead, MemWrite, IRWrite,
            ALUSrcA, ALUSrcB, ALUOp, MemToAcc, AccWrite, Halted};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: expected outputs for phase st, opcode op, AccZero az, Reset rst
  function automatic logic [19:0] model_word(input int st, input logic [3:0] op,
                                             input logic az, input logic rst);
    logic pcw, iord, mrd, mwr, irw, srca, m2a, accw, hlt;
    logic [1:0] pcsrc, srcb;
    logic [2:0] aluop;
    logic [2:0] alu_fn;
    pcw = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; srca = 0; m2a = 0;
    accw = 0; hlt = 0; pcsrc = 0; srcb = 0; aluop = 0;
    alu_fn = (op == 4'd3) ? 3'd1 : (op == 4'd4) ? 3'd2 : (op == 4'd5) ? 3'd3 : 3'd0;
    case (st)
      0: begin mrd = 1; irw = 1; srcb = 2; pcw = 1; end
      1: srcb = 1;
      2: begin mrd = 1; iord = 1; end
      3: begin srca = 1; srcb = (op == 4'd6) ? 2'd1 : 2'd0; aluop = alu_fn; end
      4: begin
        accw = 1;
        if (op == 4'd0) m2a = 1;
        else begin srca = 1; srcb = (op == 4'd6) ? 2'd1 : 2'd0; aluop = alu_fn; end
      end
      5: begin mwr = 1; iord = 1; end
      6: begin pcsrc = 2; pcw = az; end
      7: begin pcw = 1; pcsrc = 1; end
      8: hlt = 1;
      default: ;
    endcase
    if (rst) begin pcw = 0; irw = 0; mrd = 0; mwr = 0; accw = 0; hlt = 0; end
    return {4'(st), pcw, pcsrc, iord, mrd, mwr, irw, srca, srcb, aluop, m2a, accw, hlt};
  endfunction

  // Phase list for one instruction, from the cycles-per-instruction table
  task automatic load_phases(input logic [3:0] op);
    exp_q = {4'd0, 4'd1};
    case (op)
      4'd0:                   exp_q = {exp_q, 4'd2, 4'd4};
      4'd2, 4'd3, 4'd4, 4'd5: exp_q = {exp_q, 4'd2, 4'd3, 4'd4};
      4'd6:                   exp_q = {exp_q, 4'd3, 4'd4};
      4'd1:                   exp_q.push_back(4'd5);
      4'd7:                   exp_q.push_back(4'd6);
      4'd8:                   exp_q.push_back(4'd7);
      4'd15:                  exp_q.push_back(4'd8);
      default: ;
    endcase
  endtask

  // Driver: run one instruction (or its first max_ph phases), checking each cycle.
  // first_now means the caller already sits in this instruction's FETCH cycle.
  task automatic exec_instr(input logic [3:0] op, input bit first_now, input int max_ph);
    logic [3:0] st;
    int n;
    load_phases(op);
    n = 0;
    while (exp_q.size() > 0 && n < max_ph) begin
      st = exp_q.pop_front();
      if (n > 0 || !first_now) @(negedge CLK);
      Opcode  = op;
      AccZero = 1'($urandom_range(0, 1));
      #1;
      check_eq($sformatf("op%0h_st%0d", op, st), 32'(obs_word()),
               32'(model_word(int'(st), op, AccZero, 1'b0)));
      n++;
    end
  endtask

  // Driver: assert reset in the current cycle (cur_st), hold it one more cycle, release.
  task automatic reset_release(input int cur_st, input logic [3:0] op);
    Reset = 1'b1;
    #1;
    check_eq($sformatf("rst_in_st%0d", cur_st), 32'(obs_word()),
             32'(model_word(cur_st, op, AccZero, 1'b1)));
    @(negedge CLK);
    #1;
    check_eq("rst_to_fetch", 32'(obs_word()), 32'(model_word(0, op, AccZero, 1'b1)));
    Reset = 1'b0;
  endtask

  initial begin
    logic [3:0] op;
    Reset   = 1'b1;
    Opcode  = 4'b0010;
    AccZero = 1'b0;

    // Reset held two cycles: FETCH with strobes masked
    repeat (2) begin
      @(negedge CLK);
      #1;
      check_eq("reset_hold", 32'(obs_word()), 32'(model_word(0, 4'b0010, AccZero, 1'b1)));
    end
    Reset = 1'b0;

    // Directed sequence
    exec_instr(4'd3, 1'b1, 99);   // SUB
    exec_instr(4'd6, 1'b0, 99);   // ADDI
    exec_instr(4'd0, 1'b0, 99);   // LOAD
    exec_instr(4'd1, 1'b0, 99);   // STORE
    @(negedge CLK); Opcode = 4'd7; AccZero = 1'b1;  // BEQZ taken
    #1; check_eq("beqz1_fetch", 32'(obs_word()), 32'(model_word(0, 4'd7, 1'b1, 1'b0)));
    @(negedge CLK); #1;
    check_eq("beqz1_decode", 32'(obs_word()), 32'(model_word(1, 4'd7, 1'b1, 1'b0)));
    @(negedge CLK); #1;
    check_eq("beqz1_branch", 32'(obs_word()), 32'(model_word(6, 4'd7, 1'b1, 1'b0)));
    @(negedge CLK); AccZero = 1'b0;                 // BEQZ not taken
    #1; check_eq("beqz0_fetch", 32'(obs_word()), 32'(model_word(0, 4'd7, 1'b0, 1'b0)));
    @(negedge CLK); #1;
    check_eq("beqz0_decode", 32'(obs_word()), 32'(model_word(1, 4'd7, 1'b0, 1'b0)));
    @(negedge CLK); #1;
    check_eq("beqz0_branch", 32'(obs_word()), 32'(model_word(6, 4'd7, 1'b0, 1'b0)));
    exec_instr(4'd8, 1'b0, 99);   // JUMP
    exec_instr(4'hA, 1'b0, 99);   // NOP

    // Randomized instruction stream (HALT excluded)
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 14));
      exec_instr(op, 1'b0, 99);
    end

    // HALT holds across opcode changes, reset returns to FETCH
    exec_instr(4'hF, 1'b0, 99);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      Opcode  = 4'($urandom);
      AccZero = 1'($urandom_range(0, 1));
      #1;
      check_eq("halt_hold", 32'(obs_word()), 32'(model_word(8, Opcode, AccZero, 1'b0)));
    end
    @(negedge CLK);
    reset_release(8, Opcode);
    exec_instr(4'hA, 1'b1, 99);   // NOP right after reset
    exec_instr(4'd2, 1'b0, 99);   // ADD

    // Reset during ALUEXEC of an ADD: no accumulator write
    exec_instr(4'd2, 1'b0, 4);
    reset_release(3, 4'd2);
    exec_instr(4'd5, 1'b1, 99);   // OR after abort
    exec_instr(4'd4, 1'b0, 99);   // AND

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
